lut_ram_lsu: RTL and testbench

Load/store unit sitting directly upstream of the `lut_ram` data memory. Accepts byte-addressed RV32I load/store requests over a valid/ready handshake and turns them into word-wide `lut_ram` accesses. It performs read-modify-write merging for byte and halfword stores, and lane extraction plus sign or zero extension for loads. It returns a registered response one cycle after acceptance.

---
 rtl/lut_ram_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_lut_ram_lsu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_lsu.sv
// lut_ram_lsu: byte-addressed RV32I load/store front end for the word-wide lut_ram.
// Stores of bytes and halfwords are merged into the addressed word with a
// read-modify-write in the accept cycle. Loads are lane-extracted and then
// sign- or zero-extended. The response is registered one cycle after accept.
// Optional feature macro: LUT_RAM_LSU_MISALIGNED_SPLIT_EN. When it is defined,
// misaligned accesses are split over two consecutive words. When it is not
// defined, misaligned accesses are reported as errors.
module lut_ram_lsu #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 1000,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_wr_en,
    output logic [AW-1:0]   mem_wr_addr,
    output logic [AW-1:0]   mem_rd_addr,
    output logic [XLEN-1:0] mem_wr_data,
    input  logic [XLEN-1:0] mem_rd_data
);

`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE = 1'b0} state_t;
`endif

    // Byte lanes touched by an access of the given size, before the offset shift.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replace the masked byte lanes of old_w with the same lanes of new_w.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = mask[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return r;
    endfunction

    // Sign- or zero-extend a right-aligned load value according to its size.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'b01:   r = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            2'b10:   r = raw;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t      state_r;
    logic        accept_s;
    logic [29:0] index_s;
    logic [1:0]  offset_s;
    logic [31:0] idx_ext_s;
    logic        size_bad_s;
    logic        misaligned_s;
    logic        range_err_s;
    logic        err_s;
    logic [31:0] load_raw_s;
    logic [31:0] load_data_s;

`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
    logic          next_range_err_s;
    logic          go_split_s;
    logic [7:0]    lane_mask_s;
    logic [63:0]   lane_wdata_s;
    logic [31:0]   split_raw_s;
    logic [31:0]   split_load_s;
    logic [AW-1:0] split_index_r;
    logic [31:0]   split_wdata_r;
    logic [3:0]    split_mask_r;
    logic          split_we_r;
    logic [31:0]   split_low_r;
    logic [1:0]    split_off_r;
    logic [1:0]    split_size_r;
    logic          split_uns_r;
`else
    logic [3:0]    lane_mask_s;
    logic [31:0]   lane_wdata_s;
`endif

    // Request decode: error classification, lane placement and load extraction.
    always_comb begin
        req_ready    = !rst && (state_r == ST_IDLE);
        accept_s     = req_valid && req_ready;
        index_s      = req_addr[31:2];
        offset_s     = req_addr[1:0];
        idx_ext_s    = {2'b00, index_s};
        size_bad_s   = (req_size == 2'b11);
        misaligned_s = ((req_size == 2'b01) && (offset_s == 2'b11)) ||
                       ((req_size == 2'b10) && (offset_s != 2'b00));
        range_err_s  = (idx_ext_s >= 32'(MEM_DEPTH));
        load_raw_s   = mem_rd_data >> {offset_s, 3'b000};
        load_data_s  = extend_load(load_raw_s, req_size, req_unsigned);
`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
        // A split access is only legal if the following word also exists.
        next_range_err_s = ((idx_ext_s + 32'd1) >= 32'(MEM_DEPTH));
        err_s        = size_bad_s || range_err_s || (misaligned_s && next_range_err_s);
        go_split_s   = misaligned_s && !err_s;
        lane_mask_s  = {4'b0000, size_mask(req_size)} << offset_s;
        lane_wdata_s = {32'd0, req_wdata} << {offset_s, 3'b000};
        // Rebuild the loaded value from the upper bytes of the first word
        // and the lower bytes of the second word.
        case (split_off_r)
            2'b01:   split_raw_s = {mem_rd_data[7:0],  split_low_r[31:8]};
            2'b10:   split_raw_s = {mem_rd_data[15:0], split_low_r[31:16]};
            2'b11:   split_raw_s = {mem_rd_data[23:0], split_low_r[31:24]};
            default: split_raw_s = split_low_r;
        endcase
        split_load_s = extend_load(split_raw_s, split_size_r, split_uns_r);
`else
        err_s        = size_bad_s || range_err_s || misaligned_s;
        lane_mask_s  = size_mask(req_size) << offset_s;
        lane_wdata_s = req_wdata << {offset_s, 3'b000};
`endif
    end

    // Memory port drive: the accept-cycle access, or the second word of a split.
    always_comb begin
        mem_rd_addr = index_s[AW-1:0];
        mem_wr_addr = index_s[AW-1:0];
        mem_wr_data = merge_lanes(mem_rd_data, lane_wdata_s[31:0], lane_mask_s[3:0]);
        mem_wr_en   = 1'b0;
`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
        if (state_r == ST_SPLIT) begin
            mem_rd_addr = split_index_r;
            mem_wr_addr = split_index_r;
            mem_wr_data = merge_lanes(mem_rd_data, split_wdata_r, split_mask_r);
            mem_wr_en   = split_we_r && !rst;
        end else begin
            mem_wr_en   = accept_s && req_we && !err_s;
        end
`else
        if (accept_s && req_we && !err_s) begin
            mem_wr_en = 1'b1;
        end else begin
            mem_wr_en = 1'b0;
        end
`endif
    end

    // Response registers, FSM state and split bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
            split_index_r <= '0;
            split_wdata_r <= 32'd0;
            split_mask_r  <= 4'd0;
            split_we_r    <= 1'b0;
            split_low_r   <= 32'd0;
            split_off_r   <= 2'd0;
            split_size_r  <= 2'd0;
            split_uns_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
                        if (go_split_s) begin
                            // The first word is handled now; the rest is deferred one cycle.
                            state_r       <= ST_SPLIT;
                            resp_valid    <= 1'b0;
                            split_index_r <= index_s[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
                            split_wdata_r <= lane_wdata_s[63:32];
                            split_mask_r  <= lane_mask_s[7:4];
                            split_we_r    <= req_we;
                            split_low_r   <= mem_rd_data;
                            split_off_r   <= offset_s;
                            split_size_r  <= req_size;
                            split_uns_r   <= req_unsigned;
                        end else begin
                            state_r    <= ST_IDLE;
                            resp_valid <= 1'b1;
                            resp_err   <= err_s;
                            resp_rdata <= (err_s || req_we) ? 32'd0 : load_data_s;
                        end
`else
                        resp_valid <= 1'b1;
                        resp_err   <= err_s;
                        resp_rdata <= (err_s || req_we) ? 32'd0 : load_data_s;
`endif
                    end else begin
                        resp_valid <= 1'b0;
                    end
                end
`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
                ST_SPLIT: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= split_we_r ? 32'd0 : split_load_s;
                end
`endif
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_ram_lsu.sv
// Testbench for lut_ram_lsu. It attaches a behavioural lut_ram and drives
// directed and random requests. Expected responses and memory contents come
// from a byte-level reference model.
module tb_lut_ram_lsu;

    localparam int DEPTH = 1000;
    localparam int AW    = $clog2(DEPTH);
`ifdef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [31:0]   mem_wr_data, mem_rd_data;

    logic [31:0] ram     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        logic        split;
    } exp_t;
    exp_t q[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;
    logic s_v, s_e, s_rdy;
    logic [31:0] s_d;

    lut_ram_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural lut_ram: combinational read, write at the rising edge.
    assign mem_rd_data = (mem_rd_addr < AW'(DEPTH)) ? ram[mem_rd_addr] : 32'd0;
    always @(posedge clk) begin
        if (mem_wr_en && (mem_wr_addr < AW'(DEPTH))) ram[mem_wr_addr] <= mem_wr_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: apply an accepted request byte by byte and queue its response.
    task automatic model_accept(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd);
        int nb, idx, off, a;
        logic mis, bad;
        logic [31:0] v;
        exp_t e;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        idx = int'(addr >> 2);
        off = int'(addr[1:0]);
        mis = (nb != 0) && (off + nb > 4);
        bad = (sz == 2'd3) || (idx >= DEPTH) || (mis && !SPLIT_EN) || (mis && (idx + 1 >= DEPTH));
        v = 32'd0;
        if (!bad) begin
            for (int i = 0; i < nb; i++) begin
                a = idx * 4 + off + i;
                if (we) ref_mem[a / 4][8 * (a % 4) +: 8] = wd[8 * i +: 8];
                else    v[8 * i +: 8] = ref_mem[a / 4][8 * (a % 4) +: 8];
            end
            if (!we && !uns && (nb < 4) && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        e.data  = (bad || we) ? 32'd0 : v;
        e.err   = bad;
        e.split = mis && !bad;
        e.due   = cyc + (e.split ? 2 : 1);
        q.push_back(e);
    endtask

    // One request cycle: sample outputs at the falling edge, then drive the inputs.
    task automatic drive_cycle(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, output logic acc);
        @(negedge clk);
        s_v = resp_valid; s_d = resp_rdata; s_e = resp_err; s_rdy = req_ready;
        #1;
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        acc = v && req_ready && !rst;
        if (acc) model_accept(we, sz, uns, addr, wd);
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        logic acc;
        drive_cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, acc);
    endtask

    task automatic issue_nowait(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, we, sz, uns, addr, wd, acc);
            if (acc) break;
        end
        check1("accept_timeout", acc, 1'b1);
    endtask

    task automatic issue_wait(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] d, output logic e, output int lat, output int rlo);
        issue_nowait(we, sz, uns, addr, wd);
        d = 32'd0; e = 1'b0; lat = 0; rlo = 0;
        for (int k = 1; k <= 3; k++) begin
            idle_cycle();
            if (!s_rdy) rlo++;
            if (s_v) begin
                lat = k; d = s_d; e = s_e;
                break;
            end
        end
    endtask

    // Per-cycle comparison of the response channel and ready against the model.
    always @(negedge clk) begin
        logic ev, er;
        if (chk_en) begin
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            ev = (q.size() > 0) && (q[0].due == cyc);
            er = !rst;
            foreach (q[i]) if (q[i].split && (q[i].due == cyc + 1)) er = 1'b0;
            check1("resp_valid", resp_valid, ev);
            check1("req_ready", req_ready, er);
            if (ev) begin
                check("resp_rdata", resp_rdata, q[0].data);
                check1("resp_err", resp_err, q[0].err);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] d, w0, w1, addr;
        logic e, acc;
        int lat, rlo, idx, r, s, nbad;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end

        // Reset with a valid store request pending.
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check1("rst_req_ready", req_ready, 1'b0);
        check1("rst_mem_wr_en", mem_wr_en, 1'b0);
        #1; rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check1("post_rst_resp_valid", resp_valid, 1'b0);
        check("post_rst_resp_rdata", resp_rdata, 32'd0);
        chk_en = 1'b1;

        // Directed word/byte traffic with literal expectations.
        issue_wait(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, d, e, lat, rlo);
        check("sw_lat", 32'(lat), 32'd1);
        issue_wait(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, d, e, lat, rlo);
        check("lb_0x13", d, 32'hFFFF_FFDE);
        check("lb_lat", 32'(lat), 32'd1);
        issue_wait(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, d, e, lat, rlo);
        check("lbu_0x12", d, 32'h0000_00AD);
        issue_nowait(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055);
        issue_wait(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, d, e, lat, rlo);
        check("lw_after_sb", d, 32'hDEAD_55EF);
        check("lw_after_sb_lat", 32'(lat), 32'd1);
        issue_wait(1'b0, 2'd2, 1'b0, 32'hFA0, 32'd0, d, e, lat, rlo);
        check1("lw_oor_err", e, 1'b1);
        check("lw_oor_data", d, 32'd0);
        check("lw_oor_lat", 32'(lat), 32'd1);

`ifndef LUT_RAM_LSU_MISALIGNED_SPLIT_EN
        w0 = ram[0]; w1 = ram[1];
        issue_wait(1'b0, 2'd1, 1'b0, 32'h03, 32'd0, d, e, lat, rlo);
        check1("lh_mis_err", e, 1'b1);
        check("lh_mis_data", d, 32'd0);
        issue_wait(1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_1234, d, e, lat, rlo);
        check1("sh_mis_err", e, 1'b1);
        check("sh_mis_word0", ram[0], w0);
        check("sh_mis_word1", ram[1], w1);
`else
        ram[0] = 32'h4433_2211; ram[1] = 32'h8877_6655;
        ref_mem[0] = ram[0]; ref_mem[1] = ram[1];
        issue_wait(1'b0, 2'd2, 1'b0, 32'h02, 32'd0, d, e, lat, rlo);
        check("lw_split_data", d, 32'h6655_4433);
        check("lw_split_lat", 32'(lat), 32'd2);
        check("lw_split_ready_low", 32'(rlo), 32'd1);
        issue_wait(1'b1, 2'd2, 1'b0, 32'h01, 32'hAABB_CCDD, d, e, lat, rlo);
        check("sw_split_word0", ram[0], 32'hBBCC_DD11);
        check("sw_split_word1", ram[1], 32'h8877_66AA);
        // Reset during the SPLIT cycle of a misaligned store.
        ram[0] = 32'h4433_2211; ram[1] = 32'h8877_6655;
        ref_mem[0] = ram[0];
        issue_nowait(1'b1, 2'd2, 1'b0, 32'h01, 32'hAABB_CCDD);
        @(negedge clk);
        #1; req_valid = 1'b0; rst = 1'b1; q.delete();
        @(posedge clk);
        idle_cycle();
        check1("split_rst_no_resp", s_v, 1'b0);
        rst = 1'b0;
        check("split_rst_word0", ram[0], 32'hBBCC_DD11);
        check("split_rst_word1", ram[1], 32'h8877_6655);
        ref_mem[1] = 32'h8877_6655;
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      idx = $urandom_range(0, 15);
            else if (r < 88) idx = $urandom_range(990, 999);
            else if (r < 95) idx = $urandom_range(1000, 1100);
            else             idx = $urandom_range(1024, 1040);
            addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if (r == 99) addr = $urandom;
            s = $urandom_range(0, 9);
            drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3,
                        1'($urandom_range(0, 1)), addr, $urandom, acc);
        end
        repeat (4) idle_cycle();

        nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== ref_mem[i]) begin
                if (nbad < 4) $display("FAIL mem_word[%0d]: got %08h expected %08h", i, ram[i], ref_mem[i]);
                nbad++;
            end
        end
        check("mem_mismatch_words", 32'(nbad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
